period_meter: RTL and testbench
===============================

PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving the width of the measurement outputs.
REQ-002 The module SHALL have parameter TIMEOUT, default 50_000_000, giving the maximum edge-to-edge gap in clk cycles; legal range is 2 <= TIMEOUT <= 2^WIDTH-1.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The module SHALL have port sig_in, input, 1 bit: the asynchronous waveform being measured, e.g. a divided clock.
REQ-006 The module SHALL have port period, output, WIDTH bits: the clk-cycle count between the last two rising edges of sig_in.
REQ-007 The module SHALL have port high_time, output, WIDTH bits: the clk cycles sig_in was high within that period.
REQ-008 The module SHALL have port valid, output, 1 bit: a one-cycle pulse marking that period and high_time have just been updated.
REQ-009 The module SHALL have port timeout, output, 1 bit: a level that is high while no rising edge has arrived within TIMEOUT cycles.

Function
REQ-010 sig_in SHALL pass through a 2-flop synchronizer (s1, s2) and a third flop s3; rise = s2 & ~s3, evaluated combinationally.
REQ-011 The module SHALL implement an FSM with states IDLE (no reference edge) and MEASURE (reference edge captured).
REQ-012 IDLE -> MEASURE SHALL occur on rise; no measurement is emitted on this transition; timeout clears to 0 on it.
REQ-013 On every rise cycle, the cycle counter cnt SHALL load 1 and the high counter hcnt SHALL load 1.
REQ-014 In MEASURE with no rise, cnt SHALL increment by 1.
REQ-015 In MEASURE with no rise, hcnt SHALL increment when s2=1 and hold when s2=0.
REQ-016 On rise in MEASURE, the module SHALL register period <= cnt and high_time <= hcnt, pulse valid=1 for exactly one cycle, and stay in MEASURE.
REQ-017 period SHALL equal t2-t1, where t1 and t2 are consecutive rise cycles; high_time SHALL be at most period.
REQ-018 Latency: valid SHALL rise after the 3rd rising clk edge, counting the edge that first samples sig_in=1 as the 1st.
REQ-019 period and high_time SHALL hold their values between valid pulses, including across timeout.
REQ-020 Timeout: in MEASURE, when cnt == TIMEOUT and there is no rise, the next state SHALL be IDLE and timeout <= 1, with no valid pulse.
REQ-021 If rise coincides with cnt == TIMEOUT, rise SHALL take priority: the measurement is emitted (period = TIMEOUT) and timeout stays 0.
REQ-022 In IDLE, cnt and hcnt SHALL hold; timeout SHALL stay at its current value until the next rise.
REQ-023 cnt SHALL never exceed TIMEOUT; no wrap-around SHALL be possible.
REQ-024 A constant-level sig_in SHALL never produce valid.

Reset
REQ-025 While rst_n=0 at a clk edge: state SHALL be IDLE, s1=s2=s3=0, cnt=hcnt=0, period=0, high_time=0, valid=0, timeout=0.
REQ-026 Reset asserted mid-measurement SHALL discard the partial count; the first rise after release SHALL only re-arm (no valid).
REQ-027 If sig_in is high when reset releases, the synchronizer SHALL produce one rise, which arms the FSM only.

Verification
REQ-028 Stimulus: periodic sig_in, 4 cycles high / 6 cycles low, clk-aligned -> first valid at the 2nd rise; every 10 cycles thereafter period=10, high_time=4, valid high 1 cycle.
REQ-029 Stimulus: TIMEOUT=20, one rise then sig_in held low -> timeout=1 on the cycle after cnt reaches 20; valid never pulses; next rise clears timeout with no valid; the rise after that gives a valid measurement.
REQ-030 Stimulus: TIMEOUT=20, second rise exactly 20 cycles after the first -> valid=1, period=20, timeout stays 0.
REQ-031 Stimulus: rst_n pulsed low for 1 cycle mid-period of a 10-cycle waveform -> all outputs 0 at the next edge; first valid only at the 2nd rise after release, period=10.
REQ-032 Stimulus: 50% duty input, period 2 cycles (1 high/1 low) -> period=2, high_time=1 on every valid; valid pulses every 2 cycles.
REQ-033 Stimulus: period change from 10 to 16 cycles -> the first valid after the change reports 16; period holds 10 until then.

Source files
------------

// File: rtl/period_meter.sv
// -----------------------------------------------------------------------------
// period_meter
//
// Measures the period and the high time of an asynchronous waveform, in cycles
// of clk. The waveform is synchronized, rising edges are detected, and the
// cycle count between two consecutive rising edges is reported together with
// the number of those cycles for which the synchronized input was high.
//
// Parameters
//   WIDTH    width of the period / high_time outputs and internal counters
//   TIMEOUT  largest edge-to-edge gap, in clk cycles, that is still measured
//            (2 <= TIMEOUT <= 2^WIDTH-1)
//
// Ports
//   clk        single clock, all state changes on its rising edge
//   rst_n      synchronous active-low reset
//   sig_in     asynchronous waveform to be measured
//   period     clk cycles between the last two rising edges of sig_in
//   high_time  clk cycles sig_in was high within that period
//   valid      one-cycle pulse: period/high_time were updated on this cycle
//   timeout    level: no rising edge arrived within TIMEOUT cycles
//
// Output protocol: valid is a push-only strobe with no back-pressure. It is
// high for exactly one clk cycle, and period/high_time are stable from that
// cycle until the next valid pulse (also across timeout). Consumers that miss
// the pulse simply see the previous measurement held.
// -----------------------------------------------------------------------------
module period_meter #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 50_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             valid,
    output logic             timeout
);

    typedef enum logic {
        IDLE    = 1'b0,  // no reference edge yet (after reset or timeout)
        MEASURE = 1'b1   // reference edge captured, counting towards next
    } state_t;

    localparam logic [WIDTH-1:0] TIMEOUT_CNT = WIDTH'(TIMEOUT);
    localparam logic [WIDTH-1:0] ONE         = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state;
    state_t           state_next;

    logic             s1;
    logic             s2;
    logic             s3;
    logic             rise;

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] hcnt;
    logic             cnt_at_limit;

    logic             emit;
    logic             expire;

    // -------------------------------------------------------------------------
    // Synchronizer: s1/s2 resolve metastability, s3 is the previous value of
    // s2 so that a rising edge is seen for exactly one cycle.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise         = s2 & ~s3;
    assign cnt_at_limit = (cnt == TIMEOUT_CNT);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic. A rise always wins over the timeout limit, so an
    // edge arriving exactly TIMEOUT cycles after the previous one is measured.
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_next = MEASURE;
                end
            end
            MEASURE: begin
                if (!rise && cnt_at_limit) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: output decode
    //   emit   - a rise closes a measurement window (only with a reference edge)
    //   expire - the window reached its limit without a closing rise
    // -------------------------------------------------------------------------
    always_comb begin
        emit   = 1'b0;
        expire = 1'b0;
        if (state == MEASURE) begin
            emit   = rise;
            expire = ~rise & cnt_at_limit;
        end
    end

    // -------------------------------------------------------------------------
    // Counters. Both load 1 on a rise because the rise cycle itself is the
    // first cycle of the new window and s2 is high in it. cnt stops at the
    // limit (the FSM leaves MEASURE on that cycle), so it can never wrap;
    // hcnt can only advance on cycles where cnt also advances, so it is
    // bounded by cnt.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt  <= '0;
            hcnt <= '0;
        end else if (rise) begin
            cnt  <= ONE;
            hcnt <= ONE;
        end else if (state == MEASURE && !expire) begin
            cnt <= cnt + ONE;
            if (s2) begin
                hcnt <= hcnt + ONE;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Result registers and status flags.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            valid <= emit;
            if (emit) begin
                period    <= cnt;
                high_time <= hcnt;
            end
            // Any rise re-establishes edge activity; in IDLE it also re-arms.
            if (rise) begin
                timeout <= 1'b0;
            end else if (expire) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_period_meter.sv
module tb_period_meter;

  localparam int W  = 16;
  localparam int TO = 20;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic         clk    = 1'b0;
  logic         rst_n  = 1'b0;
  logic         sig_in = 1'b0;
  logic [W-1:0] period;
  logic [W-1:0] high_time;
  logic         valid;
  logic         timeout;

  always #5 clk = ~clk;

  period_meter #(
    .WIDTH   (W),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sig_in    (sig_in),
    .period    (period),
    .high_time (high_time),
    .valid     (valid),
    .timeout   (timeout)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] exp_item;
  int             n_checks = 0;
  int             n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_wave(input int h, input int l, input int n);
    for (int i = 0; i < n; i++) begin
      sig_in = 1'b1;
      tick(h);
      sig_in = 1'b0;
      tick(l);
    end
  endtask

  task automatic expect_meas(input int p, input int ht, input int n);
    repeat (n) exp_q.push_back({W'(p), W'(ht)});
  endtask

  // Hold low long enough for the meter to time out and return to IDLE.
  task automatic settle();
    sig_in = 1'b0;
    tick(TO + 6);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: every valid pulse must match the oldest expected measurement.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (rst_n && valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", 32'(valid), 32'd0);
      end else begin
        exp_item = exp_q.pop_front();
        check("period", 32'(period), 32'(exp_item[2*W-1:W]));
        check("high_time", 32'(high_time), 32'(exp_item[W-1:0]));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    // Reset values
    rst_n  = 1'b0;
    sig_in = 1'b0;
    tick(3);
    check("rst_period", 32'(period), 32'd0);
    check("rst_high_time", 32'(high_time), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // 4 high / 6 low: first rise arms, latency of the second rise checked
    run_wave(4, 6, 1);
    expect_meas(10, 4, 1);
    sig_in = 1'b1;
    tick(1);
    check("lat_edge1_valid", 32'(valid), 32'd0);
    tick(1);
    check("lat_edge2_valid", 32'(valid), 32'd0);
    tick(1);
    check("lat_edge3_valid", 32'(valid), 32'd1);
    check("lat_edge3_period", 32'(period), 32'd10);
    check("lat_edge3_high", 32'(high_time), 32'd4);
    tick(1);
    check("valid_one_cycle", 32'(valid), 32'd0);
    sig_in = 1'b0;
    tick(6);
    expect_meas(10, 4, 4);
    run_wave(4, 6, 4);
    settle();
    check("timeout_after_idle", 32'(timeout), 32'd1);
    check("period_hold_timeout", 32'(period), 32'd10);
    check("high_hold_timeout", 32'(high_time), 32'd4);

    // Timeout timing: one rise then held low
    sig_in = 1'b1;
    tick(3);
    check("timeout_clear_on_rise", 32'(timeout), 32'd0);
    tick(1);
    sig_in = 1'b0;
    tick(18);
    check("timeout_before_limit", 32'(timeout), 32'd0);
    tick(1);
    check("timeout_at_limit", 32'(timeout), 32'd1);
    sig_in = 1'b1;
    tick(3);
    check("timeout_clear_rearm", 32'(timeout), 32'd0);
    tick(1);
    sig_in = 1'b0;
    tick(6);
    expect_meas(10, 4, 1);
    run_wave(4, 6, 1);
    settle();

    // Second rise exactly TIMEOUT cycles after the first
    expect_meas(20, 4, 1);
    sig_in = 1'b1;
    tick(4);
    sig_in = 1'b0;
    tick(16);
    sig_in = 1'b1;
    tick(3);
    check("limit_valid", 32'(valid), 32'd1);
    check("limit_period", 32'(period), 32'd20);
    check("limit_timeout", 32'(timeout), 32'd0);
    tick(1);
    sig_in = 1'b0;
    tick(6);
    settle();

    // Second rise one cycle beyond TIMEOUT: times out, late rise only re-arms
    sig_in = 1'b1;
    tick(4);
    sig_in = 1'b0;
    tick(17);
    sig_in = 1'b1;
    tick(2);
    check("late_rise_timeout_set", 32'(timeout), 32'd1);
    tick(1);
    check("late_rise_clears", 32'(timeout), 32'd0);
    tick(1);
    sig_in = 1'b0;
    tick(6);
    expect_meas(10, 4, 1);
    run_wave(4, 6, 1);
    settle();

    // Reset pulse mid-period
    expect_meas(10, 4, 2);
    run_wave(4, 6, 2);
    sig_in = 1'b1;
    tick(4);
    sig_in = 1'b0;
    tick(2);
    rst_n = 1'b0;
    tick(1);
    check("midrst_period", 32'(period), 32'd0);
    check("midrst_high_time", 32'(high_time), 32'd0);
    check("midrst_valid", 32'(valid), 32'd0);
    check("midrst_timeout", 32'(timeout), 32'd0);
    rst_n = 1'b1;
    expect_meas(10, 4, 1);
    run_wave(4, 6, 2);
    settle();

    // sig_in already high when reset releases
    rst_n  = 1'b0;
    sig_in = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    check("release_high_timeout", 32'(timeout), 32'd0);
    sig_in = 1'b0;
    tick(6);
    expect_meas(9, 3, 1);
    sig_in = 1'b1;
    tick(4);
    sig_in = 1'b0;
    tick(6);
    settle();

    // Fastest waveform: 1 high / 1 low
    expect_meas(2, 1, 7);
    run_wave(1, 1, 8);
    settle();

    // Period change 10 -> 16
    expect_meas(10, 4, 2);
    run_wave(4, 6, 3);
    expect_meas(10, 4, 1);
    run_wave(4, 12, 1);
    check("period_hold_before_change", 32'(period), 32'd10);
    expect_meas(16, 4, 3);
    run_wave(4, 12, 3);
    check("period_after_change", 32'(period), 32'd16);
    settle();

    // Final report
    tick(5);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
